// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: an instruction-fetch port and a load/store port share one
// single-outstanding memory port. Data wins ties until MAX_D_BURST grants starve a waiting fetch.
module mem_arbiter #(
  parameter int MAX_D_BURST = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [2:0] BURST = 3'(MAX_D_BURST);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t     state, state_nxt;
  logic [2:0] d_streak, d_streak_nxt;
  logic       grant_i, grant_d;

  always_comb begin
    state_nxt    = state;
    d_streak_nxt = d_streak;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    i_valid      = 1'b0;
    d_valid      = 1'b0;
    case (state)
      IDLE: begin
        // Data has priority unless a waiting fetch has already been passed over BURST times.
        if (d_req && !(i_req && d_streak == BURST)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
          if (i_req && d_streak < BURST)
            d_streak_nxt = d_streak + 3'd1;
        end else if (i_req) begin
          grant_i      = 1'b1;
          state_nxt    = BUSY_I;
          d_streak_nxt = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          i_valid   = !reset;
          state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          d_valid   = !reset;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_en  = (state != IDLE);
  assign i_rdata = i_valid ? mem_rdata : '0;
  assign d_rdata = d_valid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      d_streak  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state    <= state_nxt;
      d_streak <= d_streak_nxt;
      // Access attributes are captured once at grant and stay frozen until completion.
      if (grant_d) begin
        mem_we    <= d_we;
        mem_be    <= d_be;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_we    <= 1'b0;
        mem_be    <= 4'b1111;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against an access-level reference model.
module tb_mem_arbiter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.MAX_D_BURST(MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and the captured access.
  int          m_owner  = 0;
  int          m_streak = 0;
  logic        m_we     = 1'b0;
  logic        m_store  = 1'b0;
  logic [3:0]  m_be     = 4'h0;
  logic [31:0] m_addr   = 32'h0;
  logic [31:0] m_wdata  = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic e_iv, e_dv;
    e_iv = (m_owner == 1) && mem_ready && !reset;
    e_dv = (m_owner == 2) && mem_ready && !reset;
    chk("mem_en",    32'(mem_en),    32'(m_owner != 0));
    chk("mem_we",    32'(mem_we),    32'(m_we));
    chk("mem_be",    32'(mem_be),    32'(m_be));
    chk("mem_addr",  mem_addr,       m_addr);
    chk("mem_wdata", mem_wdata,      m_wdata);
    chk("i_valid",   32'(i_valid),   32'(e_iv));
    chk("d_valid",   32'(d_valid),   32'(e_dv));
    chk("i_rdata",   i_rdata,        e_iv ? mem_rdata : 32'h0);
    if (!(e_dv && m_store))
      chk("d_rdata", d_rdata,        e_dv ? mem_rdata : 32'h0);
    chk("excl_valid", 32'(i_valid & d_valid), 32'h0);
  endtask

  task automatic model_update();
    logic pick_d;
    pick_d = d_req && !(i_req && m_streak >= MAX);
    if (reset) begin
      m_owner = 0; m_streak = 0; m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    end else if (m_owner != 0) begin
      if (mem_ready) m_owner = 0;
    end else if (pick_d) begin
      m_owner = 2;
      if (i_req) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
      m_we = d_we; m_store = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
    end else if (i_req) begin
      m_owner = 1; m_streak = 0;
      m_we = 1'b0; m_be = 4'hF; m_addr = i_addr; m_wdata = 32'h0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct packed {
    logic        rst, ireq, dreq, rdy;
    logic [31:0] rdata;
    logic        en, iv, dv;
    logic [31:0] ird;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic r, input logic i, input logic d, input logic y,
                              input logic [31:0] rd, input logic en, input logic iv,
                              input logic dv, input logic [31:0] ird);
    vec_t v;
    v.rst = r; v.ireq = i; v.dreq = d; v.rdy = y; v.rdata = rd;
    v.en = en; v.iv = iv; v.dv = dv; v.ird = ird;
    return v;
  endfunction

  int en_cnt, iv_cnt, addr_bad;

  initial begin
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset, spurious ready, single fetch, then D,D,I,D,D,I with both held.
    tbl[0]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 1, 32'hCAFE0000, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0);
    tbl[3]  = mk(0, 1, 0, 0, 32'h0,        1, 0, 0, 32'h0);
    tbl[4]  = mk(0, 1, 0, 1, 32'h00500093, 1, 1, 0, 32'h00500093);
    tbl[5]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0);
    tbl[6]  = mk(0, 1, 1, 1, 32'h0,        0, 0, 0, 32'h0);
    tbl[7]  = mk(0, 1, 1, 1, 32'h0,        1, 0, 1, 32'h0);
    tbl[8]  = mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0);
    tbl[9]  = mk(0, 1, 1, 1, 32'h0,        1, 0, 1, 32'h0);
    tbl[10] = mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0);
    tbl[11] = mk(0, 1, 1, 1, 32'h00000011, 1, 1, 0, 32'h00000011);
    tbl[12] = mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0);
    tbl[13] = mk(0, 1, 1, 1, 32'h0,        1, 0, 1, 32'h0);
    tbl[14] = mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0);
    tbl[15] = mk(0, 1, 1, 1, 32'h0,        1, 0, 1, 32'h0);
    tbl[16] = mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0);
    tbl[17] = mk(0, 1, 1, 1, 32'h00000022, 1, 1, 0, 32'h00000022);

    i_addr = 32'h00000010; d_addr = 32'h00000020; d_we = 1'b1; d_be = 4'b0011;
    d_wdata = 32'hDEADBEEF;
    for (int k = 0; k < 18; k++) begin
      reset = tbl[k].rst; i_req = tbl[k].ireq; d_req = tbl[k].dreq;
      mem_ready = tbl[k].rdy; mem_rdata = tbl[k].rdata;
      at_neg();
      chk($sformatf("tbl%0d_en", k), 32'(mem_en),  32'(tbl[k].en));
      chk($sformatf("tbl%0d_iv", k), 32'(i_valid), 32'(tbl[k].iv));
      chk($sformatf("tbl%0d_dv", k), 32'(d_valid), 32'(tbl[k].dv));
      chk($sformatf("tbl%0d_ird", k), i_rdata, tbl[k].ird);
      if (tbl[k].iv) begin
        chk($sformatf("tbl%0d_fetch_addr", k), mem_addr, 32'h10);
        chk($sformatf("tbl%0d_fetch_be", k), 32'(mem_be), 32'hF);
        chk($sformatf("tbl%0d_fetch_we", k), 32'(mem_we), 32'h0);
      end
      if (tbl[k].dv) begin
        chk($sformatf("tbl%0d_store_addr", k), mem_addr, 32'h20);
        chk($sformatf("tbl%0d_store_be", k), 32'(mem_be), 32'h3);
        chk($sformatf("tbl%0d_store_wd", k), mem_wdata, 32'hDEADBEEF);
      end
      advance();
    end

    // Three wait states on a fetch.
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; reset = 1'b1;
    at_neg(); advance();
    reset = 1'b0; i_req = 1'b1; i_addr = 32'h0000ABC0; mem_rdata = 32'h12345678;
    at_neg(); advance();
    en_cnt = 0; iv_cnt = 0; addr_bad = 0;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      at_neg();
      en_cnt += int'(mem_en);
      iv_cnt += int'(i_valid);
      if (mem_addr !== 32'h0000ABC0) addr_bad++;
      advance();
    end
    i_req = 1'b0; mem_ready = 1'b0;
    at_neg();
    chk("wait_en_cycles", 32'(en_cnt), 32'd4);
    chk("wait_valid_cnt", 32'(iv_cnt), 32'd1);
    chk("wait_addr_stable", 32'(addr_bad), 32'd0);
    chk("wait_en_after", 32'(mem_en), 32'h0);
    advance();

    // Reset while a load is outstanding, with a fetch pending.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h00000040;
    at_neg(); advance();
    at_neg();
    chk("rst_busy_en", 32'(mem_en), 32'h1);
    advance();
    reset = 1'b1; mem_ready = 1'b1; i_req = 1'b1; i_addr = 32'h00000080;
    at_neg();
    chk("rst_no_dvalid", 32'(d_valid), 32'h0);
    advance();
    reset = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    at_neg();
    chk("rst_en_low", 32'(mem_en), 32'h0);
    chk("rst_addr_zero", mem_addr, 32'h0);
    advance();
    mem_ready = 1'b1;
    at_neg();
    chk("rst_fetch_first", mem_addr, 32'h00000080);
    chk("rst_fetch_valid", 32'(i_valid), 32'h1);
    advance();
    i_req = 1'b0; mem_ready = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      i_req     = ($urandom_range(0, 3) != 0);
      d_req     = ($urandom_range(0, 3) != 0);
      d_we      = 1'($urandom);
      d_be      = 4'($urandom);
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      mem_rdata = $urandom;
      mem_ready = ($urandom_range(0, 2) != 0);
      at_neg();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
